// File: rtl/mdu_pkg.sv
// mdu_pkg: op encodings, default latencies and HI/LO result type for mdu_hilo.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_MADD  = 3'd2,
        MDU_DIV   = 3'd3,
        MDU_DIVU  = 3'd4,
        MDU_MTHI  = 3'd5,
        MDU_MTLO  = 3'd6,
        MDU_RSVD  = 3'd7
    } mdu_op_e;

    localparam int MDU_MUL_LAT = 5;
    localparam int MDU_DIV_LAT = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } mdu_result_t;

endpackage

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply/divide datapath feeding the HI/LO pending registers.
// The MADD accumulate adder and its {hi,lo} input exist only when MDU_MADD_EN is defined.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
`ifdef MDU_MADD_EN
    input  mdu_result_t hilo,
`endif
    output mdu_result_t res,
    output logic        div_zero
);
    logic [63:0] sprod, uprod, madd;
    logic [31:0] abs_a, abs_b, uq, ur, sq, sr, dvs;
    logic        rt_zero;

    assign rt_zero = rt_data == 32'd0;
    assign sprod   = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    assign uprod   = {32'd0, rs_data} * {32'd0, rt_data};
`ifdef MDU_MADD_EN
    assign madd    = hilo + sprod;
`else
    assign madd    = 64'd0;
`endif

    // A zero divisor is replaced by 1 so no X reaches the pending registers; the
    // result is discarded at commit anyway.
    assign dvs   = rt_zero ? 32'd1 : rt_data;
    assign abs_a = rs_data[31] ? -rs_data : rs_data;
    assign abs_b = rt_data[31] ? -rt_data : dvs;
    assign uq    = abs_a / abs_b;
    assign ur    = abs_a % abs_b;
    assign sq    = (rs_data[31] ^ rt_data[31]) ? -uq : uq;
    assign sr    = rs_data[31] ? -ur : ur;

    assign res = op == MDU_MULT  ? sprod :
                 op == MDU_MULTU ? uprod :
                 op == MDU_MADD  ? madd  :
                 op == MDU_DIV   ? {sr, sq} :
                 op == MDU_DIVU  ? {rs_data % dvs, rs_data / dvs} :
                 64'd0;

    assign div_zero = (op == MDU_DIV || op == MDU_DIVU) && rt_zero;
endmodule

// File: rtl/mdu_hilo.sv
// mdu_hilo: E-stage multiply/divide unit with HI/LO registers, busy counter and md stall.
// Define MDU_MADD_EN to enable op 2 (MADD); otherwise op 2 is ignored like op 7.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MDU_MUL_LAT,
    parameter int DIV_LAT = MDU_DIV_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        md_stall_d,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall
);
    localparam int CW = $clog2((MUL_LAT > DIV_LAT ? MUL_LAT : DIV_LAT) + 1);
`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    mdu_result_t   p_q, p_d, arith_res;
    logic          dz_q, dz_d, div_zero, is_mul, is_div, go;

    mdu_arith u_arith (
        .op       (op),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
`ifdef MDU_MADD_EN
        .hilo     ({hi_q, lo_q}),
`endif
        .res      (arith_res),
        .div_zero (div_zero)
    );

    assign busy   = cnt_q != '0;
    assign go     = start && !busy;
    assign is_mul = op == MDU_MULT || op == MDU_MULTU || (MADD_EN && op == MDU_MADD);
    assign is_div = op == MDU_DIV || op == MDU_DIVU;

    always_comb begin
        cnt_d = cnt_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        p_d   = p_q;
        dz_d  = dz_q;
        if (go) begin
            p_d   = (is_mul || is_div) ? arith_res : p_q;
            dz_d  = (is_mul || is_div) ? div_zero : dz_q;
            cnt_d = is_div ? CW'(DIV_LAT) : is_mul ? CW'(MUL_LAT) : cnt_q;
            hi_d  = op == MDU_MTHI ? rs_data : hi_q;
            lo_d  = op == MDU_MTLO ? rs_data : lo_q;
        end else if (cnt_q == CW'(1)) begin
            cnt_d = '0;
            hi_d  = dz_q ? hi_q : p_q.hi;
            lo_d  = dz_q ? lo_q : p_q.lo;
        end else if (busy) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
            p_q   <= '0;
            dz_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            p_q   <= p_d;
            dz_q  <= dz_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign stall = md_stall_d & (start | busy);
endmodule
